control_sequencer: RTL and testbench

Hardwired control unit that sits directly upstream of the DataPath. It owns the fetch/decode/execute state machine and drives every DataPath strobe, replacing the hand-sequenced T0–T5 stimulus. It fetches an instruction through PC/MAR/MDR/IR, decodes the opcode and register fields from the IR, runs the ALU `start`/`finished` handshake, and writes the result back. It covers R-format ALU instructions plus HALT.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/ir_decoder.sv | 43 ++++
 rtl/control_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encoding, opcodes and IR field positions.
// Macro CONTROL_SEQUENCER_MULDIV_EN makes MUL/DIV legal opcodes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

`ifdef CONTROL_SEQUENCER_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

endpackage

// File: rtl/ir_decoder.sv
// ir_decoder: splits IR into opcode/Ra/Rb/Rc and classifies the opcode.
// in: ir[31:0]; out: opcode, ra, rb, rc, is_alu, is_muldiv, is_halt, is_illegal.
module ir_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic        is_alu,
  output logic        is_muldiv,
  output logic        is_halt,
  output logic        is_illegal
);

  logic unused_bits;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rc     = ir[RC_MSB:RC_LSB];

  assign unused_bits = ^ir[RC_LSB-1:0];

  always_comb begin
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:
        is_alu = 1'b1;
      OP_MUL, OP_DIV:
        is_muldiv = MULDIV_EN;
      OP_HALT:
        is_halt = 1'b1;
      default: ;
    endcase
    is_illegal = !(is_alu || is_muldiv || is_halt);
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute FSM driving DataPath strobes.
// in: Clock, clear(async low), run, ir, finished; out: bus/load strobes,
// Read, IncPC, start, RFSelect, opSelect, halted, fault.
// Macro CONTROL_SEQUENCER_MULDIV_EN adds MUL/DIV with the T6 HI writeback.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT    = 1,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        finished,
  output logic        PCout,
  output logic        RFout,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        MDRout,
  output logic        PCin,
  output logic        MARin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        RFin,
  output logic        RHIin,
  output logic        RLOin,
  output logic        MDRin,
  output logic        Read,
  output logic        IncPC,
  output logic        start,
  output logic [3:0]  RFSelect,
  output logic [5:0]  opSelect,
  output logic        halted,
  output logic        fault
);

  localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t state, next;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tcnt;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic is_alu, is_muldiv, is_halt, is_illegal;

  ir_decoder u_dec (
    .ir         (ir),
    .opcode     (opcode),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= next;
  end

  // wcnt is loaded in T0 so T1 holds exactly MEM_WAIT cycles.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      wcnt <= '0;
    end else if (state == S_T0) begin
      wcnt <= WW'(MEM_WAIT - 1);
    end else if (state == S_T1 && wcnt != '0) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  // tcnt counts T4 cycles; zero marks the first T4 cycle.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)              tcnt <= '0;
    else if (state == S_T4)  tcnt <= tcnt + 1'b1;
    else                     tcnt <= '0;
  end

  always_comb begin
    next     = state;
    PCout    = 1'b0;
    RFout    = 1'b0;
    RZLOout  = 1'b0;
    RZHIout  = 1'b0;
    MDRout   = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    RFin     = 1'b0;
    RHIin    = 1'b0;
    RLOin    = 1'b0;
    MDRin    = 1'b0;
    Read     = 1'b0;
    IncPC    = 1'b0;
    start    = 1'b0;
    RFSelect = 4'd0;
    opSelect = 6'd0;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) next = S_T0;
      end
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        RZin  = 1'b1;
        next  = S_T1;
      end
      S_T1: begin
        RZLOout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (wcnt == '0) next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        next   = S_T3;
      end
      S_T3: begin
        if (is_halt) begin
          next = S_HALT;
        end else if (is_illegal) begin
          next = S_FAULT;
        end else begin
          RFout    = 1'b1;
          RYin     = 1'b1;
          RFSelect = rb;
          next     = S_T4;
        end
      end
      S_T4: begin
        RFout    = 1'b1;
        RFSelect = rc;
        RZin     = 1'b1;
        opSelect = {1'b0, opcode};
        start    = (tcnt == '0);
        if (finished)
          next = S_T5;
        else if (tcnt == TW'(ALU_TIMEOUT - 1))
          next = S_FAULT;
      end
      S_T5: begin
        RZLOout = 1'b1;
        if (is_muldiv) begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
          RLOin = 1'b1;
          next  = S_T6;
`else
          next  = S_FAULT;
`endif
        end else begin
          RFin     = 1'b1;
          RFSelect = ra;
          next     = run ? S_T0 : S_IDLE;
        end
      end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
      S_T6: begin
        RZHIout = 1'b1;
        RHIin   = 1'b1;
        next    = run ? S_T0 : S_IDLE;
      end
`endif
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven scoreboard bench for control_sequencer.
// Honours CONTROL_SEQUENCER_MULDIV_EN when choosing MUL/DIV expectations.
module tb_control_sequencer;

  typedef struct packed {
    logic pcout, rfout, rzloout, rzhiout, mdrout;
    logic pcin, marin, irin, ryin, rzin, rfin;
    logic rhiin, rloin, mdrin, read, incpc, start;
    logic [3:0] rfsel;
    logic [5:0] opsel;
    logic halted, fault;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
    logic  run;
    logic  fin;
  } sb_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          kind;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    int          d;
    bit          noise;
    bit          chain;
  } vec_t;

  localparam int K_ALU  = 0;
  localparam int K_MD   = 1;
  localparam int K_HALT = 2;
  localparam int K_ILL  = 3;
  localparam int NV     = 10;

  logic Clock, clear, run, run3, finished, finished3;
  logic [31:0] ir;

  logic PCout, RFout, RZLOout, RZHIout, MDRout, PCin, MARin, IRin, RYin;
  logic RZin, RFin, RHIin, RLOin, MDRin, Read, IncPC, start, halted, fault;
  logic [3:0] RFSelect;
  logic [5:0] opSelect;

  logic o3_PCout, o3_RFout, o3_RZLOout, o3_RZHIout, o3_MDRout, o3_PCin;
  logic o3_MARin, o3_IRin, o3_RYin, o3_RZin, o3_RFin, o3_RHIin, o3_RLOin;
  logic o3_MDRin, o3_Read, o3_IncPC, o3_start, o3_halted, o3_fault;
  logic [3:0] o3_RFSelect;
  logic [5:0] o3_opSelect;

  out_t got, got3;

  assign got = {PCout, RFout, RZLOout, RZHIout, MDRout, PCin, MARin, IRin,
                RYin, RZin, RFin, RHIin, RLOin, MDRin, Read, IncPC, start,
                RFSelect, opSelect, halted, fault};
  assign got3 = {o3_PCout, o3_RFout, o3_RZLOout, o3_RZHIout, o3_MDRout,
                 o3_PCin, o3_MARin, o3_IRin, o3_RYin, o3_RZin, o3_RFin,
                 o3_RHIin, o3_RLOin, o3_MDRin, o3_Read, o3_IncPC, o3_start,
                 o3_RFSelect, o3_opSelect, o3_halted, o3_fault};

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .run(run), .ir(ir), .finished(finished),
    .PCout(PCout), .RFout(RFout), .RZLOout(RZLOout), .RZHIout(RZHIout),
    .MDRout(MDRout), .PCin(PCin), .MARin(MARin), .IRin(IRin), .RYin(RYin),
    .RZin(RZin), .RFin(RFin), .RHIin(RHIin), .RLOin(RLOin), .MDRin(MDRin),
    .Read(Read), .IncPC(IncPC), .start(start), .RFSelect(RFSelect),
    .opSelect(opSelect), .halted(halted), .fault(fault)
  );

  control_sequencer #(.MEM_WAIT(3)) dut3 (
    .Clock(Clock), .clear(clear), .run(run3), .ir(ir), .finished(finished3),
    .PCout(o3_PCout), .RFout(o3_RFout), .RZLOout(o3_RZLOout),
    .RZHIout(o3_RZHIout), .MDRout(o3_MDRout), .PCin(o3_PCin),
    .MARin(o3_MARin), .IRin(o3_IRin), .RYin(o3_RYin), .RZin(o3_RZin),
    .RFin(o3_RFin), .RHIin(o3_RHIin), .RLOin(o3_RLOin), .MDRin(o3_MDRin),
    .Read(o3_Read), .IncPC(o3_IncPC), .start(o3_start),
    .RFSelect(o3_RFSelect), .opSelect(o3_opSelect), .halted(o3_halted),
    .fault(o3_fault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  sb_t q[$];
  vec_t vt[NV];

  task automatic chk(input string tag, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, g, e);
    end
  endtask

  task automatic chki(input string tag, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, g, e);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op,
    input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'h0};
  endfunction

  function automatic out_t w_t0();
    out_t w = '0;
    w.pcout = 1'b1; w.marin = 1'b1; w.incpc = 1'b1; w.rzin = 1'b1;
    return w;
  endfunction

  function automatic out_t w_t1();
    out_t w = '0;
    w.rzloout = 1'b1; w.pcin = 1'b1; w.read = 1'b1; w.mdrin = 1'b1;
    return w;
  endfunction

  function automatic out_t w_t2();
    out_t w = '0;
    w.mdrout = 1'b1; w.irin = 1'b1;
    return w;
  endfunction

  function automatic out_t w_t3(input logic [3:0] rb);
    out_t w = '0;
    w.rfout = 1'b1; w.ryin = 1'b1; w.rfsel = rb;
    return w;
  endfunction

  function automatic out_t w_t4(input logic [3:0] rc,
    input logic [4:0] op, input logic st);
    out_t w = '0;
    w.rfout = 1'b1; w.rfsel = rc; w.rzin = 1'b1;
    w.opsel = {1'b0, op}; w.start = st;
    return w;
  endfunction

  function automatic out_t w_t5(input logic [3:0] ra);
    out_t w = '0;
    w.rzloout = 1'b1; w.rfin = 1'b1; w.rfsel = ra;
    return w;
  endfunction

  function automatic out_t w_t5md();
    out_t w = '0;
    w.rzloout = 1'b1; w.rloin = 1'b1;
    return w;
  endfunction

  function automatic out_t w_t6();
    out_t w = '0;
    w.rzhiout = 1'b1; w.rhiin = 1'b1;
    return w;
  endfunction

  function automatic out_t w_halt();
    out_t w = '0;
    w.halted = 1'b1;
    return w;
  endfunction

  function automatic out_t w_fault();
    out_t w = '0;
    w.fault = 1'b1;
    return w;
  endfunction

  task automatic push(input string tag, input out_t e,
    input logic r, input logic f);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    s.run = r;
    s.fin = f;
    q.push_back(s);
  endtask

  task automatic build(input vec_t v);
    int kind = v.kind;
    logic rm = v.chain;
`ifndef CONTROL_SEQUENCER_MULDIV_EN
    if (kind == K_MD) kind = K_ILL;
`endif
    push({v.name, ":IDLE"}, '0, 1'b1, v.noise);
    push({v.name, ":T0"}, w_t0(), rm, v.noise);
    push({v.name, ":T1"}, w_t1(), rm, v.noise);
    push({v.name, ":T2"}, w_t2(), rm, v.noise);
    if (kind == K_ALU || kind == K_MD) begin
      push({v.name, ":T3"}, w_t3(v.rb), rm, v.noise);
      for (int k = 0; k <= v.d; k++)
        push({v.name, ":T4"}, w_t4(v.rc, v.op, k == 0), rm, k == v.d);
      if (kind == K_ALU) begin
        push({v.name, ":T5"}, w_t5(v.ra), v.chain, v.noise);
      end else begin
        push({v.name, ":T5lo"}, w_t5md(), rm, v.noise);
        push({v.name, ":T6hi"}, w_t6(), v.chain, v.noise);
      end
      if (v.chain) push({v.name, ":next_T0"}, w_t0(), 1'b0, 1'b0);
      else         push({v.name, ":end_IDLE"}, '0, 1'b0, 1'b0);
    end else begin
      push({v.name, ":T3"}, '0, 1'b1, v.noise);
      for (int k = 0; k < 4; k++) begin
        if (kind == K_HALT) push({v.name, ":HALT"}, w_halt(), 1'b1, 1'b1);
        else                push({v.name, ":FAULT"}, w_fault(), 1'b1, 1'b1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    clear = 1'b0;
    run = 1'b0;
    run3 = 1'b0;
    finished = 1'b0;
    #1;
    chk("reset", got, '0);
    chk("reset_mw3", got3, '0);
    #1;
    clear = 1'b1;
  endtask

  task automatic drain();
    sb_t s;
    while (q.size() > 0) begin
      @(negedge Clock);
      s = q.pop_front();
      chk(s.tag, got, s.exp);
      run = s.run;
      finished = s.fin;
    end
  endtask

  initial begin
    int n4, seen, cur, mx, tot;
    clear = 1'b0;
    run = 1'b0;
    run3 = 1'b0;
    finished = 1'b0;
    finished3 = 1'b1;
    ir = '0;

    vt[0] = '{"add", 32'h20918000, K_ALU, 5'b00100,
              4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b0};
    vt[1] = '{"sub", mk_ir(5'b00101, 4'd7, 4'd8, 4'd9), K_ALU, 5'b00101,
              4'd7, 4'd8, 4'd9, 0, 1'b1, 1'b0};
    vt[2] = '{"rol", mk_ir(5'b01011, 4'd15, 4'd0, 4'd14), K_ALU, 5'b01011,
              4'd15, 4'd0, 4'd14, 3, 1'b0, 1'b1};
    vt[3] = '{"shr", mk_ir(5'b01000, 4'd4, 4'd5, 4'd6), K_ALU, 5'b01000,
              4'd4, 4'd5, 4'd6, 2, 1'b1, 1'b0};
    vt[4] = '{"or", mk_ir(5'b00111, 4'd10, 4'd11, 4'd12), K_ALU, 5'b00111,
              4'd10, 4'd11, 4'd12, 0, 1'b0, 1'b1};
    vt[5] = '{"mul", 32'h70228000, K_MD, 5'b01110,
              4'd0, 4'd4, 4'd5, 0, 1'b0, 1'b0};
    vt[6] = '{"div", mk_ir(5'b01111, 4'd3, 4'd2, 4'd1), K_MD, 5'b01111,
              4'd3, 4'd2, 4'd1, 1, 1'b1, 1'b1};
    vt[7] = '{"ill0", mk_ir(5'b00000, 4'd1, 4'd1, 4'd1), K_ILL, 5'b00000,
              4'd1, 4'd1, 4'd1, 0, 1'b0, 1'b0};
    vt[8] = '{"ill1f", mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), K_ILL, 5'b11111,
              4'd2, 4'd3, 4'd4, 0, 1'b1, 1'b0};
    vt[9] = '{"halt", 32'hD8000000, K_HALT, 5'b11011,
              4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      do_reset();
      ir = vt[i].ir;
      build(vt[i]);
      drain();
    end

    // ALU never finishes: FAULT after ALU_TIMEOUT T4 cycles.
    do_reset();
    ir = vt[0].ir;
    run = 1'b1;
    n4 = 0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge Clock);
      if (RFout && RZin) n4++;
      if (fault) seen = 1;
    end
    chki("timeout_t4_cycles", n4, 64);
    chki("timeout_fault", seen, 1);
    @(negedge Clock);
    chk("timeout_absorbing", got, w_fault());

    // MEM_WAIT=3 instance holds Read/MDRin for three cycles.
    do_reset();
    ir = vt[0].ir;
    run3 = 1'b1;
    cur = 0;
    mx = 0;
    tot = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge Clock);
      if (o3_Read && o3_MDRin) begin
        cur++;
        tot++;
        if (cur > mx) mx = cur;
      end else begin
        cur = 0;
      end
      if (o3_IRin) seen = 1;
    end
    chki("memwait_run", mx, 3);
    chki("memwait_total", tot, 3);
    chki("memwait_reached_T2", seen, 1);

    // clear pulsed in the middle of T4.
    do_reset();
    ir = vt[0].ir;
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge Clock);
      if (start) seen = 1;
    end
    chki("clr_start_seen", seen, 1);
    @(negedge Clock);
    clear = 1'b0;
    #1;
    chk("clr_async", got, '0);
    run = 1'b0;
    @(negedge Clock);
    chk("clr_held", got, '0);
    clear = 1'b1;
    @(negedge Clock);
    chk("clr_idle", got, '0);
    run = 1'b1;
    @(negedge Clock);
    chk("clr_restart_T0", got, w_t0());
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
